pipe_mem_wb: RTL and testbench
==============================

PIPE_MEM_WB -- requirements
Module: pipe_mem_wb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of wdata, hi and lo.
REQ-002 SHALL have parameter ADDR_W, default 5, width of waddr.
REQ-003 SHALL have parameter ZERO_DISCARD, default 1; when 1, a GPR write to address 0 is suppressed at the output.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port mem_valid, input, 1, upstream entry present.
REQ-007 SHALL have port mem_ready, output, 1, stage can accept an entry this cycle.
REQ-008 SHALL have ports mem_we (input, 1), mem_waddr (input, ADDR_W) and mem_wdata (input, DATA_W), the GPR write payload.
REQ-009 SHALL have ports mem_we_hilo (input, 1), mem_hi (input, DATA_W) and mem_lo (input, DATA_W), the HI/LO write payload.
REQ-010 SHALL have port flush, input, 1, discard all held entries.
REQ-011 SHALL have port wb_valid, output, 1, head entry present.
REQ-012 SHALL have port wb_ready, input, 1, writeback consumes the head entry.
REQ-013 SHALL have ports wb_we, wb_waddr, wb_wdata, wb_we_hilo, wb_hi and wb_lo, outputs, widths matching the mem_* ports, the head payload.
REQ-014 SHALL have port occ, output, 2, number of held entries (0..2).

Function
REQ-015 SHALL implement a two-entry skid buffer with a main register and a skid register, plus states EMPTY (occ=0), ONE (occ=1) and FULL (occ=2).
REQ-016 SHALL drive mem_ready = (state != FULL) from registered state only, with no combinational path from wb_ready.
REQ-017 SHALL define accept = mem_valid & mem_ready & !flush and pop = wb_valid & wb_ready.
REQ-018 SHALL, in EMPTY, load the main register on accept and go to ONE.
REQ-019 SHALL, in ONE: on accept & pop, load main and stay in ONE; on accept & !pop, load skid and go to FULL; on !accept & pop, go to EMPTY.
REQ-020 SHALL, in FULL: on pop, move skid to main and go to ONE; otherwise hold.
REQ-021 SHALL, on flush (highest priority, same edge), go to EMPTY and drop any simultaneous mem_valid entry; a pop in the same cycle still counts as consumed.
REQ-022 SHALL give latency of exactly 1 cycle from accept into EMPTY to wb_valid=1.
REQ-023 SHALL drive wb_valid = (state != EMPTY), with the wb_* payload always taken from the main register.
REQ-024 SHALL gate wb_we = main.we & wb_valid & !(ZERO_DISCARD & main.waddr==0).
REQ-025 SHALL gate wb_we_hilo = main.we_hilo & wb_valid.
REQ-026 SHALL hold the payload stable while wb_valid & !wb_ready, and SHALL never duplicate or reorder entries.
REQ-027 SHALL leave the payload registers unchanged on non-load cycles; only the valid state is cleared on flush.

Reset
REQ-028 SHALL, while rst_n=0 (asynchronously), force state EMPTY, wb_valid=0, mem_ready=1, occ=0, and all payload registers to 0.
REQ-029 SHALL, after rst_n deasserts mid-operation, hold no entry; in-flight entries are lost by design.

Structure
REQ-030 SHALL take the shared package definitions (pipe_pkg): state enum (EMPTY/ONE/FULL), a payload struct type {we, waddr, wdata, we_hilo, hi, lo} parametrised by width constants, and DATA_W/ADDR_W defaults.
REQ-031 SHALL contain one sub-module, pipe_skid_reg (a single payload register with load enable and async reset), instantiated twice for main and skid.

Verification
REQ-032 SHALL cover: reset, then mem_valid=1, we=1, waddr=3, wdata=0xDEADBEEF with wb_ready=1 -> next cycle wb_valid=1, wb_we=1, wb_waddr=3, wb_wdata=0xDEADBEEF, occ=1.
REQ-033 SHALL cover: wb_ready=0 while 3 entries A, B, C are offered back-to-back -> A and B accepted, mem_ready=0 after B, occ=2, C held upstream; then wb_ready=1 -> outputs A, B, C in order, one per cycle.
REQ-034 SHALL cover: waddr=0, we=1, wdata=0x1234 with ZERO_DISCARD=1 -> wb_valid=1, wb_we=0; the same stimulus with ZERO_DISCARD=0 -> wb_we=1.
REQ-035 SHALL cover: occ=2 with flush=1 and mem_valid=1 in the same cycle -> next cycle occ=0, wb_valid=0, mem_ready=1, and the offered entry is never seen at the output.
REQ-036 SHALL cover: mem_we_hilo=1, hi=0xAAAA0000, lo=0x0000BBBB accepted -> next cycle wb_we_hilo=1 with matching wb_hi and wb_lo; wb_we_hilo=0 whenever wb_valid=0.
REQ-037 SHALL cover: rst_n pulsed low between clock edges while occ=2 -> wb_valid=0 and occ=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM/WB pipeline register: FSM state encoding,
// default widths and the GPR + HI/LO write payload layout.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Writeback payload at the default widths; the RTL packs the same field
    // order {we, waddr, wdata, we_hilo, hi, lo} into a flat vector so the
    // widths can be overridden per instance.
    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] waddr;
        logic [DATA_W_DEF-1:0] wdata;
        logic                  we_hilo;
        logic [DATA_W_DEF-1:0] hi;
        logic [DATA_W_DEF-1:0] lo;
    } payload_t;

    function automatic int payload_width(input int dw, input int aw);
        return 2 + aw + 3 * dw;
    endfunction

endpackage

// File: rtl/pipe_mem_wb_if.sv
// MEM -> WB handshake bus: upstream entry, flush, writeback head and occupancy.
interface pipe_mem_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we_hilo;
    logic [DATA_W-1:0] mem_hi;
    logic [DATA_W-1:0] mem_lo;
    logic              flush;
    logic              wb_valid;
    logic              wb_ready;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_we_hilo;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic [1:0]        occ;

    // Producer side (MEM stage and writeback consumer as seen by a driver).
    modport master (
        output mem_valid, mem_we, mem_waddr, mem_wdata, mem_we_hilo, mem_hi, mem_lo,
        output flush, wb_ready,
        input  mem_ready, wb_valid, wb_we, wb_waddr, wb_wdata, wb_we_hilo, wb_hi, wb_lo, occ
    );

    // The pipeline register itself.
    modport slave (
        input  mem_valid, mem_we, mem_waddr, mem_wdata, mem_we_hilo, mem_hi, mem_lo,
        input  flush, wb_ready,
        output mem_ready, wb_valid, wb_we, wb_waddr, wb_wdata, wb_we_hilo, wb_hi, wb_lo, occ
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Single payload register with load enable; clears asynchronously on reset.
module pipe_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] data_q;

    // Capture d_i only on load; otherwise hold the previous payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;
endmodule

// File: rtl/pipe_mem_wb.sv
// MEM/WB pipeline register built as a two-entry skid buffer. mem_ready is a
// pure function of registered state, so wb_ready never reaches upstream
// combinationally. The head entry always lives in the main register.
module pipe_mem_wb
    import pipe_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int ZERO_DISCARD = 1
) (
    input logic          clk,
    input logic          rst_n,
    pipe_mem_wb_if.slave bus
);
    localparam int PW = payload_width(DATA_W, ADDR_W);

    state_e            state_q, state_d;
    logic              accept, pop;
    logic              main_ld, skid_ld, main_from_skid;
    logic              mem_ready_int, wb_valid_int;
    logic [1:0]        occ_int;
    logic [PW-1:0]     in_pay, main_d, main_q, skid_q;
    logic              m_we, m_we_hilo, zero_hit;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata, m_hi, m_lo;

    assign in_pay = {bus.mem_we, bus.mem_waddr, bus.mem_wdata,
                     bus.mem_we_hilo, bus.mem_hi, bus.mem_lo};

    // A flushed cycle never accepts, so a simultaneous offer is dropped.
    assign accept = bus.mem_valid & mem_ready_int & ~bus.flush;
    assign pop    = wb_valid_int & bus.wb_ready;

    // Occupancy state register; reset empties the buffer immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and payload load enables; flush wins and leaves payload untouched.
    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_ld = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_ld = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d        = ONE;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Handshake status decoded from registered state only.
    always_comb begin
        mem_ready_int = 1'b1;
        wb_valid_int  = 1'b0;
        occ_int       = 2'd0;
        case (state_q)
            EMPTY: begin
                mem_ready_int = 1'b1;
                wb_valid_int  = 1'b0;
                occ_int       = 2'd0;
            end
            ONE: begin
                mem_ready_int = 1'b1;
                wb_valid_int  = 1'b1;
                occ_int       = 2'd1;
            end
            FULL: begin
                mem_ready_int = 1'b0;
                wb_valid_int  = 1'b1;
                occ_int       = 2'd2;
            end
            default: begin
                mem_ready_int = 1'b1;
                wb_valid_int  = 1'b0;
                occ_int       = 2'd0;
            end
        endcase
    end

    assign main_d = main_from_skid ? skid_q : in_pay;

    pipe_skid_reg #(.W(PW)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (main_ld),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_skid_reg #(.W(PW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (skid_ld),
        .d_i   (in_pay),
        .q_o   (skid_q)
    );

    assign {m_we, m_waddr, m_wdata, m_we_hilo, m_hi, m_lo} = main_q;

    // Writes to r0 are architecturally void, so optionally squash them here.
    assign zero_hit = (ZERO_DISCARD != 0) && (m_waddr == '0);

    assign bus.mem_ready  = mem_ready_int;
    assign bus.wb_valid   = wb_valid_int;
    assign bus.occ        = occ_int;
    assign bus.wb_we      = m_we & wb_valid_int & ~zero_hit;
    assign bus.wb_waddr   = m_waddr;
    assign bus.wb_wdata   = m_wdata;
    assign bus.wb_we_hilo = m_we_hilo & wb_valid_int;
    assign bus.wb_hi      = m_hi;
    assign bus.wb_lo      = m_lo;
endmodule

// File: tb/tb_pipe_mem_wb.sv
// Directed bench for pipe_mem_wb: a vector table of single-cycle steps plus
// hand-written back-pressure and asynchronous-reset sequences. Two instances
// share identical stimulus, one with ZERO_DISCARD=1 and one with 0.
module tb_pipe_mem_wb;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_mem_wb_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    pipe_mem_wb_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

    pipe_mem_wb #(.DATA_W(32), .ADDR_W(5), .ZERO_DISCARD(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    pipe_mem_wb #(.DATA_W(32), .ADDR_W(5), .ZERO_DISCARD(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    typedef struct {
        logic        mv, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        wh;
        logic [31:0] hi, lo;
        logic        fl, rdy;
        logic        ev, ewe, ewe0;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic        ewh;
        logic [31:0] ehi, elo;
        logic [1:0]  eocc;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    function automatic vec_t row(
        input logic mv, input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic wh, input logic [31:0] hi, input logic [31:0] lo,
        input logic fl, input logic rdy,
        input logic ev, input logic ewe, input logic ewe0, input logic [4:0] ewa,
        input logic [31:0] ewd, input logic ewh, input logic [31:0] ehi,
        input logic [31:0] elo, input logic [1:0] eocc);
        vec_t v;
        v.mv = mv;   v.we = we;   v.wa = wa;     v.wd = wd;   v.wh = wh;
        v.hi = hi;   v.lo = lo;   v.fl = fl;     v.rdy = rdy;
        v.ev = ev;   v.ewe = ewe; v.ewe0 = ewe0; v.ewa = ewa; v.ewd = ewd;
        v.ewh = ewh; v.ehi = ehi; v.elo = elo;   v.eocc = eocc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic wh, input logic [31:0] hi,
                         input logic [31:0] lo, input logic fl, input logic rdy);
        bus1.mem_valid = mv; bus1.mem_we = we; bus1.mem_waddr = wa; bus1.mem_wdata = wd;
        bus1.mem_we_hilo = wh; bus1.mem_hi = hi; bus1.mem_lo = lo;
        bus1.flush = fl; bus1.wb_ready = rdy;
        bus0.mem_valid = mv; bus0.mem_we = we; bus0.mem_waddr = wa; bus0.mem_wdata = wd;
        bus0.mem_we_hilo = wh; bus0.mem_hi = hi; bus0.mem_lo = lo;
        bus0.flush = fl; bus0.wb_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //        mv we wa  wd            wh hi            lo            fl rdy | ev we we0 ewa ewd           ewh ehi           elo           occ
        vecs[0]  = row(1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 1,  1, 1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 1);
        vecs[1]  = row(0, 0, 0, 0,            0, 0, 0, 0, 1,  0, 0, 0, 0, 0,            0, 0, 0, 0);
        vecs[2]  = row(1, 1, 0, 32'h1234,     0, 0, 0, 0, 1,  1, 0, 1, 0, 32'h1234,     0, 0, 0, 1);
        vecs[3]  = row(1, 0, 7, 0, 1, 32'hAAAA0000, 32'h0000BBBB, 0, 1,
                       1, 0, 0, 7, 0, 1, 32'hAAAA0000, 32'h0000BBBB, 1);
        vecs[4]  = row(0, 0, 0, 0,            0, 0, 0, 0, 0,
                       1, 0, 0, 7, 0, 1, 32'hAAAA0000, 32'h0000BBBB, 1);
        vecs[5]  = row(0, 0, 0, 0,            0, 0, 0, 0, 1,  0, 0, 0, 0, 0,            0, 0, 0, 0);
        vecs[6]  = row(1, 1, 5, 32'h11,       0, 0, 0, 0, 0,  1, 1, 1, 5, 32'h11,       0, 0, 0, 1);
        vecs[7]  = row(1, 1, 6, 32'h22,       0, 0, 0, 0, 0,  1, 1, 1, 5, 32'h11,       0, 0, 0, 2);
        vecs[8]  = row(1, 1, 9, 32'h99,       0, 0, 0, 1, 0,  0, 0, 0, 0, 0,            0, 0, 0, 0);
        vecs[9]  = row(0, 0, 0, 0,            0, 0, 0, 0, 1,  0, 0, 0, 0, 0,            0, 0, 0, 0);
        vecs[10] = row(1, 1, 12, 32'hC,       0, 0, 0, 0, 0,  1, 1, 1, 12, 32'hC,       0, 0, 0, 1);
        vecs[11] = row(1, 1, 13, 32'hD,       0, 0, 0, 0, 0,  1, 1, 1, 12, 32'hC,       0, 0, 0, 2);
        vecs[12] = row(0, 0, 0, 0,            0, 0, 0, 0, 1,  1, 1, 1, 13, 32'hD,       0, 0, 0, 1);
        vecs[13] = row(0, 0, 0, 0,            0, 0, 0, 0, 1,  0, 0, 0, 0, 0,            0, 0, 0, 0);
        vecs[14] = row(1, 1, 1, 32'h1,        0, 0, 0, 0, 0,  1, 1, 1, 1, 32'h1,        0, 0, 0, 1);
        vecs[15] = row(0, 0, 0, 0,            0, 0, 0, 1, 1,  0, 0, 0, 0, 0,            0, 0, 0, 0);

        // Reset state, asserted from time zero and released between edges.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("reset wb_valid",  64'(bus1.wb_valid),  64'(0));
        chk("reset mem_ready", 64'(bus1.mem_ready), 64'(1));
        chk("reset occ",       64'(bus1.occ),       64'(0));
        chk("reset wb_wdata",  64'(bus1.wb_wdata),  64'(0));
        chk("reset wb_we",     64'(bus1.wb_we),     64'(0));
        #9;
        rst_n = 1'b1;
        tick();
        chk("post-reset occ", 64'(bus1.occ), 64'(0));

        // Table of single-cycle steps: drive, clock, compare.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].mv, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].wh,
                  vecs[i].hi, vecs[i].lo, vecs[i].fl, vecs[i].rdy);
            tick();
            chk($sformatf("r%0d wb_valid", i),   64'(bus1.wb_valid),   64'(vecs[i].ev));
            chk($sformatf("r%0d occ", i),        64'(bus1.occ),        64'(vecs[i].eocc));
            chk($sformatf("r%0d mem_ready", i),  64'(bus1.mem_ready),  64'(vecs[i].eocc != 2'd2));
            chk($sformatf("r%0d wb_we", i),      64'(bus1.wb_we),      64'(vecs[i].ewe));
            chk($sformatf("r%0d wb_we zd0", i),  64'(bus0.wb_we),      64'(vecs[i].ewe0));
            chk($sformatf("r%0d wb_we_hilo", i), 64'(bus1.wb_we_hilo), 64'(vecs[i].ewh));
            if (vecs[i].ev) begin
                chk($sformatf("r%0d wb_waddr", i), 64'(bus1.wb_waddr), 64'(vecs[i].ewa));
                chk($sformatf("r%0d wb_wdata", i), 64'(bus1.wb_wdata), 64'(vecs[i].ewd));
                chk($sformatf("r%0d wb_hi", i),    64'(bus1.wb_hi),    64'(vecs[i].ehi));
                chk($sformatf("r%0d wb_lo", i),    64'(bus1.wb_lo),    64'(vecs[i].elo));
            end
        end

        // Back-pressure: A and B fill the buffer, C waits upstream, then drain in order.
        drive(1, 1, 21, 32'hA0A0, 0, 0, 0, 0, 0);
        chk("abc ready before A", 64'(bus1.mem_ready), 64'(1));
        tick();
        chk("abc occ after A",    64'(bus1.occ),       64'(1));
        chk("abc head A",         64'(bus1.wb_wdata),  64'(32'hA0A0));
        drive(1, 1, 22, 32'hB0B0, 0, 0, 0, 0, 0);
        chk("abc ready before B", 64'(bus1.mem_ready), 64'(1));
        tick();
        chk("abc occ after B",    64'(bus1.occ),       64'(2));
        chk("abc ready after B",  64'(bus1.mem_ready), 64'(0));
        drive(1, 1, 23, 32'hC0C0, 0, 0, 0, 0, 0);
        tick();
        chk("abc occ C held",     64'(bus1.occ),       64'(2));
        chk("abc head still A",   64'(bus1.wb_wdata),  64'(32'hA0A0));
        drive(1, 1, 23, 32'hC0C0, 0, 0, 0, 0, 1);
        #1;
        chk("abc out A valid",    64'(bus1.wb_valid),  64'(1));
        chk("abc out A",          64'(bus1.wb_wdata),  64'(32'hA0A0));
        tick();
        chk("abc out B",          64'(bus1.wb_wdata),  64'(32'hB0B0));
        chk("abc occ at B",       64'(bus1.occ),       64'(1));
        chk("abc ready at B",     64'(bus1.mem_ready), 64'(1));
        tick();
        chk("abc out C",          64'(bus1.wb_wdata),  64'(32'hC0C0));
        chk("abc out C waddr",    64'(bus1.wb_waddr),  64'(23));
        chk("abc occ at C",       64'(bus1.occ),       64'(1));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("abc drained valid",  64'(bus1.wb_valid),  64'(0));
        chk("abc drained occ",    64'(bus1.occ),       64'(0));

        // Asynchronous reset pulse between edges while full.
        drive(1, 1, 2, 32'h5555, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 4, 32'h6666, 0, 0, 0, 0, 0);
        tick();
        chk("areset pre occ", 64'(bus1.occ), 64'(2));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset wb_valid",  64'(bus1.wb_valid),  64'(0));
        chk("areset occ",       64'(bus1.occ),       64'(0));
        chk("areset mem_ready", 64'(bus1.mem_ready), 64'(1));
        chk("areset wb_wdata",  64'(bus1.wb_wdata),  64'(0));
        #1;
        rst_n = 1'b1;
        tick();
        chk("areset after occ",      64'(bus1.occ),      64'(0));
        chk("areset after wb_valid", 64'(bus1.wb_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
